// File: rtl/event_ts_pkg.sv
// Shared defaults for the event timestamper and its record layout.
// Records are packed {ch, ts}: channel index in the upper bits, timestamp in the lower bits.
package event_ts_pkg;
    localparam int DEF_NUM_CH = 2;
    localparam int DEF_TS_W   = 16;
    localparam int DEF_DEPTH  = 8;
endpackage

// File: rtl/ts_fifo.sv
// Synchronous record FIFO with registered pointers and a combinational head read.
// Latency: a write is visible at the head on the cycle after the write edge.
// Backpressure: writes while full and reads while empty are ignored.
module ts_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [LW-1:0] level
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    assign wr_ok   = wr_en && (level != LW'(DEPTH));
    assign rd_ok   = rd_en && (level != '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/event_timestamper.sv
// Captures the cycle-count timestamp of every rising event edge and queues {ch, ts} records.
// Latency: edge sampled at edge k, FIFO write at k+1, out_valid in the cycle after k+1.
// Backpressure: full FIFO holds one pending edge per channel; a further edge is dropped and flagged.
module event_timestamper
    import event_ts_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int TS_W   = DEF_TS_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int CH_W  = $clog2(NUM_CH),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ev_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [TS_W-1:0]   out_ts,
    output logic [LW-1:0]     level,
    output logic              overflow,
    input  logic              clr_ovf
);
    localparam int RW = CH_W + TS_W;

    logic [TS_W-1:0]   ts_cnt;
    logic [NUM_CH-1:0] ev_q;
    logic [NUM_CH-1:0] pend;
    logic [TS_W-1:0]   pend_ts [NUM_CH];
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] wr_sel;
    logic [CH_W-1:0]   win;
    logic              win_vld;
    logic              wr_en;
    logic              rd_en;
    logic              drop;
    logic [RW-1:0]     wr_data;
    logic [RW-1:0]     rd_data;

    assign rise = {NUM_CH{enable}} & ev_i & ~ev_q;

    // Fixed priority: the lowest pending index wins.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (pend[c]) begin
                win     = CH_W'(c);
                win_vld = 1'b1;
            end
        end
    end

    // A pop in the same cycle does not free a slot for the write.
    assign wr_en   = win_vld && (level < LW'(DEPTH));
    assign wr_sel  = wr_en ? (NUM_CH'(1) << win) : '0;
    assign wr_data = {win, pend_ts[win]};
    assign drop    = |(rise & pend & ~wr_sel);

    assign out_valid = (level != '0);
    assign rd_en     = out_valid && out_ready;
    assign out_ch    = out_valid ? rd_data[RW-1:TS_W] : '0;
    assign out_ts    = out_valid ? rd_data[TS_W-1:0] : '0;

    always_ff @(posedge clk) begin
        ev_q <= ev_i;
        if (rst) begin
            ts_cnt   <= '0;
            pend     <= '0;
            overflow <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                pend_ts[c] <= '0;
            end
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_sel[c]) begin
                    // Channel leaving for the FIFO this cycle can take a new edge without loss.
                    if (rise[c]) begin
                        pend_ts[c] <= ts_cnt;
                    end else begin
                        pend[c] <= 1'b0;
                    end
                end else if (rise[c] && !pend[c]) begin
                    pend[c]    <= 1'b1;
                    pend_ts[c] <= ts_cnt;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    ts_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .level   (level)
    );
endmodule

// File: tb/tb_event_timestamper.sv
// Bench: directed scenarios with literal expectations, then random traffic checked every cycle
// against a queue-based model on two instances (16-bit and 4-bit timestamps).
module tb_event_timestamper;
    localparam int NUM_CH = 2;
    localparam int DEPTH  = 8;

    typedef struct {
        int ch;
        int ts;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] ev;
    logic       out_ready;
    logic       clr_ovf;

    logic        ov, ovf;
    logic [0:0]  och;
    logic [15:0] ots;
    logic [3:0]  lvl;
    logic        ov_w, ovf_w;
    logic [0:0]  och_w;
    logic [3:0]  ots_w;
    logic [3:0]  lvl_w;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 0;

    rec_t       m_q[$];
    bit [1:0]   m_pend = '0;
    int         m_pts[2] = '{0, 0};
    bit [1:0]   m_evq = '0;
    bit         m_ovf = 0;
    int         m_cnt = 0;
    int         m_w;
    bit         m_wr, m_pop, m_set, m_rise;
    rec_t       m_rec;

    always #5 clk = ~clk;

    event_timestamper #(.NUM_CH(NUM_CH), .TS_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ev_i(ev),
        .out_valid(ov), .out_ready(out_ready), .out_ch(och), .out_ts(ots),
        .level(lvl), .overflow(ovf), .clr_ovf(clr_ovf)
    );

    event_timestamper #(.NUM_CH(NUM_CH), .TS_W(4), .DEPTH(DEPTH)) dut_w (
        .clk(clk), .rst(rst), .enable(enable), .ev_i(ev),
        .out_valid(ov_w), .out_ready(out_ready), .out_ch(och_w), .out_ts(ots_w),
        .level(lvl_w), .overflow(ovf_w), .clr_ovf(clr_ovf)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: full-width cycle count, one queue of records, one pending slot per channel.
    always @(posedge clk) begin
        if (rst) begin
            m_cnt  = 0;
            m_pend = '0;
            m_ovf  = 0;
            m_q.delete();
        end else begin
            m_w = -1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (m_pend[c] && m_w < 0) m_w = c;
            end
            m_wr  = (m_w >= 0) && (m_q.size() < DEPTH);
            m_pop = (m_q.size() != 0) && out_ready;
            m_set = 0;
            if (m_wr) begin
                m_rec.ch = m_w;
                m_rec.ts = m_pts[m_w];
            end
            for (int c = 0; c < NUM_CH; c++) begin
                m_rise = enable && ev[c] && !m_evq[c];
                if (m_wr && c == m_w) begin
                    if (m_rise) m_pts[c] = m_cnt;
                    else        m_pend[c] = 0;
                end else if (m_rise) begin
                    if (m_pend[c]) m_set = 1;
                    else begin
                        m_pend[c] = 1;
                        m_pts[c]  = m_cnt;
                    end
                end
            end
            if (m_set)        m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            if (m_pop) void'(m_q.pop_front());
            if (m_wr)  m_q.push_back(m_rec);
            m_cnt++;
        end
        m_evq = ev;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("valid",   ov,    int'(m_q.size() != 0));
            chk("level",   lvl,   m_q.size());
            chk("ovf",     ovf,   m_ovf);
            chk("valid_w", ov_w,  int'(m_q.size() != 0));
            chk("level_w", lvl_w, m_q.size());
            chk("ovf_w",   ovf_w, m_ovf);
            if (m_q.size() != 0) begin
                chk("ch",   och,   m_q[0].ch);
                chk("ts",   ots,   m_q[0].ts & 16'hffff);
                chk("ch_w", och_w, m_q[0].ch);
                chk("ts_w", ots_w, m_q[0].ts & 4'hf);
            end
        end
    end

    initial begin
        rst = 1; ev = '0; enable = 1; out_ready = 1; clr_ovf = 0;
        tick(3);
        chk_on = 1;
        chk("rst_valid", ov, 0);
        chk("rst_ch", och, 0);
        chk("rst_ts", ots, 0);
        chk("rst_level", lvl, 0);
        chk("rst_ovf", ovf, 0);

        // Single edge sampled at ts 5.
        rst = 0;
        tick(5);
        ev = 2'b01; tick(1);
        ev = 2'b00; tick(1);
        chk("single_valid", ov, 1);
        chk("single_ch", och, 0);
        chk("single_ts", ots, 5);
        tick(1);
        chk("single_drained", lvl, 0);

        // Simultaneous edges at ts 10.
        out_ready = 0;
        tick(2);
        ev = 2'b11; tick(1);
        ev = 2'b00; tick(2);
        chk("simul_level", lvl, 2);
        chk("simul_ch0", och, 0);
        chk("simul_ts0", ots, 10);
        out_ready = 1; tick(1);
        chk("simul_ch1", och, 1);
        chk("simul_ts1", ots, 10);
        tick(1);
        chk("simul_drained", lvl, 0);

        // Full FIFO: 9 edges fill it plus one pending, 10th is dropped.
        out_ready = 0;
        for (int i = 0; i < 9; i++) begin
            ev = 2'b01; tick(1);
            ev = 2'b00; tick(3);
        end
        chk("full_level", lvl, 8);
        chk("full_no_ovf", ovf, 0);
        chk("full_head_ts", ots, 15);
        ev = 2'b01; tick(1);
        ev = 2'b00;
        chk("full_ovf", ovf, 1);
        chk("full_level2", lvl, 8);
        clr_ovf = 1; tick(1);
        clr_ovf = 0;
        chk("clr_ovf", ovf, 0);
        ev = 2'b01; clr_ovf = 1; tick(1);
        ev = 2'b00; clr_ovf = 0;
        chk("ovf_set_wins", ovf, 1);
        tick(2);
        out_ready = 1; tick(11);
        chk("full_drained", lvl, 0);
        chk("ovf_sticky", ovf, 1);
        clr_ovf = 1; tick(1);
        clr_ovf = 0;

        // Wrap on the 4-bit instance: ts 15 then ts 1.
        out_ready = 0;
        rst = 1; tick(1);
        rst = 0;
        tick(15);
        ev = 2'b01; tick(1);
        ev = 2'b00; tick(1);
        ev = 2'b01; tick(1);
        ev = 2'b00; tick(1);
        chk("wrap_level", lvl_w, 2);
        chk("wrap_ts0", ots_w, 15);
        chk("wrap_ts0_wide", ots, 15);
        out_ready = 1; tick(1);
        chk("wrap_ts1", ots_w, 1);
        chk("wrap_ts1_wide", ots, 17);
        tick(1);

        // Line high through reset gives no record; edges while disabled are ignored.
        ev = 2'b11; rst = 1; tick(2);
        rst = 0; tick(4);
        chk("hi_thru_rst", lvl, 0);
        ev = 2'b00; tick(1);
        enable = 0;
        ev = 2'b10; tick(1);
        ev = 2'b00; tick(1);
        ev = 2'b10; tick(1);
        ev = 2'b00; tick(2);
        chk("disabled", lvl, 0);
        enable = 1;
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            ev = 2'b01; tick(1);
            ev = 2'b00; tick(1);
        end
        tick(1);
        chk("pre_rst_level", lvl, 3);
        rst = 1; tick(1);
        chk("mid_rst_level", lvl, 0);
        chk("mid_rst_valid", ov, 0);
        rst = 0;

        // Random traffic: first phase mostly stalled, second mostly draining.
        for (int i = 0; i < 3000; i++) begin
            ev        = 2'($urandom);
            enable    = ($urandom_range(0, 9) != 0);
            out_ready = (i < 1500) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
            clr_ovf   = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        rst = 0; ev = '0; clr_ovf = 0; out_ready = 1; enable = 1;
        tick(20);
        chk("final_drained", lvl, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/event_timestamper.md
Name: event_timestamper

Overview:
- Receive-side counterpart to the delayed-event/clock-generation stimulus used in the SystemVerilog tests.
- Watches NUM_CH event lines and captures the cycle-count timestamp of every rising edge.
- Queues {channel, timestamp} records in a FIFO and presents them on a valid/ready read port.
- Used to check event ordering and delays in hardware instead of through $display.

Parameters:
- NUM_CH, 2, number of event input channels (>=2).
- TS_W, 16, timestamp counter width.
- DEPTH, 8, FIFO depth in records (power of 2, >=2).
- CH_W, $clog2(NUM_CH), channel index width (derived; do not override).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  capture enable; edges seen while low are ignored.
- ev_i  in  NUM_CH  event lines, synchronous to clk.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts head record.
- out_ch  out  CH_W  channel of head record.
- out_ts  out  TS_W  timestamp of head record.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: an event was lost.
- clr_ovf  in  1  clears overflow.

Behaviour:
- Reset values: out_valid=0, out_ch=0, out_ts=0, level=0, overflow=0.
- Reset also clears ts_cnt=0, every pend[c]=0 and the FIFO pointers.
- During rst, ev_q<=ev_i, so a line already high at reset release gives no edge.
- ts_cnt: free-running; +1 every cycle outside reset; wraps from 2^TS_W-1 to 0; unaffected by enable.
- Edge detect at clk edge k: rise[c] = enable & ev_i[c] & ~ev_q[c]; ev_q<=ev_i every cycle.
- Capture at edge k when rise[c]:
  - If pend[c]=0: pend[c]<=1 and pend_ts[c]<=ts_cnt (value before the increment at k).
  - If pend[c]=1 at edge k and c is not written at k: new edge dropped, overflow<=1.
  - If pend[c]=1 and c is written to the FIFO at k: pend[c] stays 1 and pend_ts[c] is reloaded (no loss).
- Arbiter: fixed priority, lowest index pending channel wins.
  - One FIFO write per cycle, only when level<DEPTH.
  - A write clears the winner's pend bit unless the same-cycle reload above applies.
- Full FIFO: no write, even if a pop occurs in the same cycle; pending entries wait, so loss happens only through the pend[c]=1 rule.
- Latency: edge sampled at clock edge k -> FIFO write at edge k+1 (if uncontested and not full) -> out_valid=1 in the cycle after k+1.
- Read port:
  - out_ch and out_ts show the head record whenever out_valid=1.
  - A pop occurs on out_valid & out_ready at the clock edge.
  - out_valid = (level!=0).
  - Holding out_ready=1 drains one record per cycle.
- level: +1 on write, -1 on pop, unchanged on both or neither.
- overflow: set has priority over clr_ovf in the same cycle.
- enable falling: pending entries still drain; edges are not captured while low; ev_q keeps tracking.
- Reset mid-operation: all records and pending entries are discarded; state is exactly the reset values at the next cycle.

Decomposition:
- Package event_ts_pkg: default parameter constants; record field ordering {ch, ts}.
- Sub-module ts_fifo: synchronous FIFO with width CH_W+TS_W and depth DEPTH.
  - Ports: wr_en, wr_data, rd_en, rd_data, level.
  - Registered pointers, combinational head read.
- Top-level module holds the timestamp counter, edge detect, pending registers, arbiter and overflow flag.

Test Plan:
- Single edge: rst released at cycle 0; ev_i[0] rises so it is sampled high at the cycle-5 edge (ts_cnt=5); out_ready=1 -> out_valid pulses the cycle after edge 6 with out_ch=0, out_ts=5; level returns to 0.
- Simultaneous edges: ev_i=2'b11 sampled at ts 10 -> two records, ch0 first then ch1, both with out_ts=10, written on consecutive cycles.
- Full FIFO: out_ready=0; 10 edges on ch0 spaced 4 cycles apart -> level saturates at 8; 9th edge held pending; 10th edge sets overflow=1; draining yields 9 records in ts order.
- Wrap: TS_W=4; edge sampled at ts_cnt=15, next at ts_cnt=1 -> out_ts values 15 then 1.
- Reset/enable: ev_i held high through rst -> no record after release; with enable=0, toggle ev_i[1] -> no record; rst asserted with level=3 -> level=0, out_valid=0 on the next cycle.
- clr_ovf: with overflow=1, pulse clr_ovf -> overflow=0; clr_ovf in the same cycle as a drop -> overflow stays 1.
